// File: rtl/vehicle_light_ctrl_if.sv
// Signal bundle between the light controller and its environment (button, crosswalk unit, lamps).
// The controller uses the slave modport; the environment/testbench drives through master.
interface vehicle_light_ctrl_if;
  logic       ped_button;
  logic       ped_done;
  logic       car_green;
  logic       car_orange;
  logic       car_red;
  logic       ped_go;
  logic       req_pending;
  logic       timeout_err;
  logic [2:0] state_dbg;

  modport master (
    output ped_button, ped_done,
    input  car_green, car_orange, car_red, ped_go, req_pending, timeout_err, state_dbg
  );

  modport slave (
    input  ped_button, ped_done,
    output car_green, car_orange, car_red, ped_go, req_pending, timeout_err, state_dbg
  );
endinterface

// File: rtl/vehicle_light_ctrl.sv
// Vehicle/pedestrian crossing controller: Moore FSM sequenced by one shared 16-bit down-counter.
// Lamps and ped_go decode from the state register only, so an async reset drops them immediately.
module vehicle_light_ctrl #(
  parameter int TVALUE       = 4,
  parameter int GREEN_MULT   = 3,
  parameter int ORANGE_MULT  = 1,
  parameter int CLEAR_MULT   = 1,
  parameter int TIMEOUT_MULT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vehicle_light_ctrl_if.slave   bus
);

  localparam logic [15:0] GREEN_LD   = 16'(GREEN_MULT * TVALUE - 1);
  localparam logic [15:0] ORANGE_LD  = 16'(ORANGE_MULT * TVALUE - 1);
  localparam logic [15:0] CLEAR_LD   = 16'(CLEAR_MULT * TVALUE - 1);
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_MULT * TVALUE - 1);

  typedef enum logic [2:0] {
    S_GREEN      = 3'd0,
    S_GREEN_HOLD = 3'd1,
    S_ORANGE     = 3'd2,
    S_CLEAR1     = 3'd3,
    S_PED_GRANT  = 3'd4,
    S_CLEAR2     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        terr_q, terr_d;
  logic        expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_GREEN;
      cnt_q   <= GREEN_LD;
      pend_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      terr_q  <= terr_d;
    end
  end

  assign expired = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    // The button is ignored during the grant; the clear on grant entry overrides this below.
    pend_d  = pend_q | (bus.ped_button && (state_q != S_PED_GRANT));
    case (state_q)
      S_GREEN: begin
        if (expired) begin
          if (pend_q) begin
            state_d = S_ORANGE;
            cnt_d   = ORANGE_LD;
          end else begin
            state_d = S_GREEN_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GREEN_HOLD: begin
        if (pend_q) begin
          state_d = S_ORANGE;
          cnt_d   = ORANGE_LD;
        end
      end
      S_ORANGE: begin
        if (expired) begin
          state_d = S_CLEAR1;
          cnt_d   = CLEAR_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CLEAR1: begin
        if (expired) begin
          state_d = S_PED_GRANT;
          cnt_d   = TIMEOUT_LD;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PED_GRANT: begin
        // ped_done wins over a coincident timeout, so no error is flagged then.
        if (bus.ped_done) begin
          state_d = S_CLEAR2;
          cnt_d   = CLEAR_LD;
        end else if (expired) begin
          state_d = S_CLEAR2;
          cnt_d   = CLEAR_LD;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CLEAR2: begin
        if (expired) begin
          state_d = S_GREEN;
          cnt_d   = GREEN_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_GREEN;
        cnt_d   = GREEN_LD;
      end
    endcase
  end

  assign bus.car_green   = (state_q == S_GREEN) || (state_q == S_GREEN_HOLD);
  assign bus.car_orange  = (state_q == S_ORANGE);
  assign bus.car_red     = (state_q == S_CLEAR1) || (state_q == S_PED_GRANT) || (state_q == S_CLEAR2);
  assign bus.ped_go      = (state_q == S_PED_GRANT);
  assign bus.req_pending = pend_q;
  assign bus.timeout_err = terr_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_vehicle_light_ctrl.sv
// Bench for vehicle_light_ctrl: directed timeline scenarios plus random traffic, all checked
// cycle-by-cycle against a phase/elapsed-time model, with literal pins on key cycles.
module tb_vehicle_light_ctrl;
  localparam int TV = 4;
  localparam int W  = 6; // {green, orange, red, ped_go, req_pending, timeout_err}

  localparam int P_GREEN = 0, P_HOLD = 1, P_ORANGE = 2, P_CLEAR1 = 3, P_GRANT = 4, P_CLEAR2 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];

  int m_phase;
  int m_el;
  bit m_pend;
  bit m_terr;

  vehicle_light_ctrl_if bus();

  vehicle_light_ctrl #(
    .TVALUE(4), .GREEN_MULT(3), .ORANGE_MULT(1), .CLEAR_MULT(1), .TIMEOUT_MULT(4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock: posedges at 5, 15, 25, ...; negedges at 10, 20, ...
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int dur(input int ph);
    case (ph)
      P_GREEN:  return 3 * TV;
      P_ORANGE: return 1 * TV;
      P_CLEAR1: return 1 * TV;
      P_GRANT:  return 4 * TV;
      P_CLEAR2: return 1 * TV;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic g, o, r, go;
    g  = (m_phase == P_GREEN) || (m_phase == P_HOLD);
    o  = (m_phase == P_ORANGE);
    r  = (m_phase == P_CLEAR1) || (m_phase == P_GRANT) || (m_phase == P_CLEAR2);
    go = (m_phase == P_GRANT);
    return {g, o, r, go, m_pend, m_terr};
  endfunction

  task automatic model_reset();
    m_phase = P_GREEN;
    m_el    = 0;
    m_pend  = 1'b0;
    m_terr  = 1'b0;
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_el    = 0;
  endtask

  task automatic model_step(input bit btn, input bit done);
    bit pend_n;
    bit last;
    pend_n = m_pend | (btn && (m_phase != P_GRANT));
    last   = (m_el == dur(m_phase) - 1);
    case (m_phase)
      P_GREEN:  if (last) enter(m_pend ? P_ORANGE : P_HOLD); else m_el++;
      P_HOLD:   if (m_pend) enter(P_ORANGE);
      P_ORANGE: if (last) enter(P_CLEAR1); else m_el++;
      P_CLEAR1: if (last) begin enter(P_GRANT); pend_n = 1'b0; end else m_el++;
      P_GRANT: begin
        if (done) enter(P_CLEAR2);
        else if (last) begin enter(P_CLEAR2); m_terr = 1'b1; end
        else m_el++;
      end
      P_CLEAR2: if (last) enter(P_GREEN); else m_el++;
      default:  enter(P_GREEN);
    endcase
    m_pend = pend_n;
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] dut_vec();
    return {bus.car_green, bus.car_orange, bus.car_red, bus.ped_go, bus.req_pending, bus.timeout_err};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: at the negedge compare cycle-k outputs, then drive inputs sampled at edge k.
  task automatic cycle(input logic btn, input logic done);
    logic [W-1:0] act, exp;
    logic ok_lamps;
    @(negedge clk);
    act = dut_vec();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL exp_queue_empty cyc=%0d actual=%b required=none", cyc, act);
    end else begin
      exp = exp_q.pop_front();
      check_vec("model", act, exp);
    end
    ok_lamps = ($countones({bus.car_green, bus.car_orange, bus.car_red}) == 1) &&
               (!bus.ped_go || bus.car_red);
    check_bit("lamp_invariant", ok_lamps, 1'b1);
    bus.ped_button = btn;
    bus.ped_done   = done;
    model_step(btn, done);
    exp_q.push_back(model_vec());
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.ped_button = 1'b0;
    bus.ped_done   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_vec());
    cyc = 0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.ped_button = 1'b0;
    bus.ped_done   = 1'b0;
    model_reset();

    // Reset values while reset is held
    #3;
    check_vec("reset_hold", dut_vec(), 6'b100000);

    // Button at 2, ped_done at 25
    do_reset();
    for (int k = 0; k <= 31; k++) begin
      cyc = k;
      cycle(k == 2, k == 25);
      if (k == 11) check_bit("s1_green11", bus.car_green, 1'b1);
      if (k == 12) check_bit("s1_orange12", bus.car_orange, 1'b1);
      if (k == 16) check_bit("s1_red16", bus.car_red, 1'b1);
      if (k == 19) check_bit("s1_go19", bus.ped_go, 1'b0);
      if (k == 20) check_bit("s1_go20", bus.ped_go, 1'b1);
      if (k == 25) check_bit("s1_go25", bus.ped_go, 1'b1);
      if (k == 26) check_vec("s1_clear2_26", dut_vec(), 6'b001000);
      if (k == 30) check_vec("s1_green30", dut_vec(), 6'b100000);
    end

    // No press until 40
    do_reset();
    for (int k = 0; k <= 47; k++) begin
      cyc = k;
      cycle(k == 40, 1'b0);
      if (k == 39) check_vec("s2_hold39", dut_vec(), 6'b100000);
      if (k == 41) check_vec("s2_pend41", dut_vec(), 6'b100010);
      if (k == 42) check_bit("s2_orange42", bus.car_orange, 1'b1);
      if (k == 45) check_bit("s2_orange45", bus.car_orange, 1'b1);
      if (k == 46) check_bit("s2_red46", bus.car_red, 1'b1);
    end

    // Grant times out
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      cyc = k;
      cycle(k == 2, 1'b0);
      if (k == 35) check_vec("s3_go35", dut_vec(), 6'b001100);
      if (k == 36) check_vec("s3_terr36", dut_vec(), 6'b001001);
      if (k == 40) check_vec("s3_terr40", dut_vec(), 6'b100001);
    end

    // ped_done coincides with timeout expiry: no error
    do_reset();
    for (int k = 0; k <= 37; k++) begin
      cyc = k;
      cycle(k == 2, k == 35);
      if (k == 36) check_vec("s4_coincide36", dut_vec(), 6'b001000);
    end

    // Button held throughout
    do_reset();
    for (int k = 0; k <= 46; k++) begin
      cyc = k;
      cycle(1'b1, k == 25);
      if (k == 22) check_vec("s5_grant22", dut_vec(), 6'b001100);
      if (k == 27) check_vec("s5_clear2_27", dut_vec(), 6'b001010);
      if (k == 41) check_bit("s5_green41", bus.car_green, 1'b1);
      if (k == 42) check_bit("s5_orange42", bus.car_orange, 1'b1);
    end

    // Async reset mid-grant
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      cyc = k;
      cycle(k == 2, 1'b0);
    end
    check_bit("s6_go_before", bus.ped_go, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_vec("s6_async_reset", dut_vec(), 6'b100000);

    // Random traffic with occasional resets
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int k = 0; k < 250; k++) begin
        cyc = k;
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 11 + 8 * blk) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
